// File: rtl/sys_ctrl_rx_cmd_pkg.sv
// Shared constants and state encoding for the received-command parser.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register-file slots the ALU reads its operands from
  localparam int REG_A = 0;
  localparam int REG_B = 1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_OP_A     = 4'd5,
    ST_OP_B     = 4'd6,
    ST_ALU_FUN  = 4'd7,
    ST_ALU_WAIT = 4'd8,
    ST_PUSH_RD  = 4'd9,
    ST_PUSH_LO  = 4'd10,
    ST_PUSH_HI  = 4'd11
  } state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WR) || (b == CMD_RD) || (b == CMD_ALU_OP) || (b == CMD_ALU_NOP);
  endfunction

endpackage

// File: rtl/sys_ctrl_rx_cmd_if.sv
// Bundle of the parser's receive, register-file, ALU and TX FIFO signals.
interface sys_ctrl_rx_cmd_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4,
  parameter int ALU_W  = 16
);
  logic [DATA_W-1:0] rx_p_data;
  logic              rx_d_vld;
  logic [DATA_W-1:0] rf_rd_data;
  logic              rf_rd_vld;
  logic [ALU_W-1:0]  alu_out;
  logic              alu_out_vld;
  logic              fifo_full;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic              rf_wr_en;
  logic              rf_rd_en;
  logic [FUN_W-1:0]  alu_fun;
  logic              alu_en;
  logic              alu_clk_en;
  logic [DATA_W-1:0] fifo_wr_data;
  logic              fifo_wr_en;
  logic              cmd_err;

  modport master (
    input  rx_p_data, rx_d_vld, rf_rd_data, rf_rd_vld, alu_out, alu_out_vld, fifo_full,
    output rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_fun, alu_en, alu_clk_en,
           fifo_wr_data, fifo_wr_en, cmd_err
  );

  modport slave (
    output rx_p_data, rx_d_vld, rf_rd_data, rf_rd_vld, alu_out, alu_out_vld, fifo_full,
    input  rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_fun, alu_en, alu_clk_en,
           fifo_wr_data, fifo_wr_en, cmd_err
  );
endinterface

// File: rtl/sys_ctrl_rx_cmd_resp_push.sv
// Response buffer (read byte or 2-byte ALU result) and fifo_full-gated push.
// push_ack is combinational so the parser advances in the same cycle the push is registered.
module sys_ctrl_resp_push #(
  parameter int DATA_W = 8,
  parameter int BUF_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BUF_W-1:0]  load_dat,
  input  logic              push_req,
  input  logic              push_hi,
  input  logic              fifo_full,
  output logic              push_ack,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data
);

  logic [BUF_W-1:0]  resp_q, resp_d;
  logic              fifo_wr_en_q, fifo_wr_en_d;
  logic [DATA_W-1:0] fifo_wr_data_q, fifo_wr_data_d;

  always_comb begin
    push_ack       = push_req & ~fifo_full;
    resp_d         = load ? load_dat : resp_q;
    fifo_wr_en_d   = push_ack;
    fifo_wr_data_d = fifo_wr_data_q;
    if (push_ack) begin
      fifo_wr_data_d = push_hi ? resp_q[2*DATA_W-1:DATA_W] : resp_q[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_q         <= '0;
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= '0;
    end else begin
      resp_q         <= resp_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_wr_data_q <= fifo_wr_data_d;
    end
  end

  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_wr_data = fifo_wr_data_q;

endmodule

// File: rtl/sys_ctrl_rx_cmd.sv
// Parses UART command frames into register-file/ALU strobes and queues response bytes.
// All outputs registered (strobes one cycle after the trigger); responses stall on fifo_full.
module sys_ctrl_rx_cmd
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4,
  parameter int ALU_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  sys_ctrl_rx_cmd_if.master bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic              rf_rd_en_q, rf_rd_en_d;
  logic [FUN_W-1:0]  alu_fun_q, alu_fun_d;
  logic              alu_en_q, alu_en_d;
  logic              alu_clk_en_q, alu_clk_en_d;
  logic              cmd_err_q, cmd_err_d;

  logic              rx_vld;
  logic [DATA_W-1:0] rx_dat;
  logic              resp_load, push_req, push_hi, push_ack;
  logic [ALU_W-1:0]  resp_dat;
  logic              fifo_wr_en_w;
  logic [DATA_W-1:0] fifo_wr_data_w;

  assign rx_vld = bus.rx_d_vld;
  assign rx_dat = bus.rx_p_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      alu_fun_q    <= '0;
      alu_en_q     <= 1'b0;
      alu_clk_en_q <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      alu_fun_q    <= alu_fun_d;
      alu_en_q     <= alu_en_d;
      alu_clk_en_q <= alu_clk_en_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_vld) begin
          if      (rx_dat == CMD_WR)      state_d = ST_WR_ADDR;
          else if (rx_dat == CMD_RD)      state_d = ST_RD_ADDR;
          else if (rx_dat == CMD_ALU_OP)  state_d = ST_OP_A;
          else if (rx_dat == CMD_ALU_NOP) state_d = ST_ALU_FUN;
        end
      end
      ST_WR_ADDR:  if (rx_vld) state_d = ST_WR_DATA;
      ST_WR_DATA:  if (rx_vld) state_d = ST_IDLE;
      ST_RD_ADDR:  if (rx_vld) state_d = ST_RD_WAIT;
      ST_RD_WAIT:  if (bus.rf_rd_vld) state_d = ST_PUSH_RD;
      ST_OP_A:     if (rx_vld) state_d = ST_OP_B;
      ST_OP_B:     if (rx_vld) state_d = ST_ALU_FUN;
      ST_ALU_FUN:  if (rx_vld) state_d = ST_ALU_WAIT;
      ST_ALU_WAIT: if (bus.alu_out_vld) state_d = ST_PUSH_LO;
      ST_PUSH_RD:  if (push_ack) state_d = ST_IDLE;
      ST_PUSH_LO:  if (push_ack) state_d = ST_PUSH_HI;
      ST_PUSH_HI:  if (push_ack) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_fun_d    = alu_fun_q;
    alu_en_d     = 1'b0;
    alu_clk_en_d = 1'b0;
    cmd_err_d    = 1'b0;
    resp_load    = 1'b0;
    resp_dat     = bus.alu_out;
    push_req     = (state_q == ST_PUSH_RD) || (state_q == ST_PUSH_LO) || (state_q == ST_PUSH_HI);
    push_hi      = (state_q == ST_PUSH_HI);
    case (state_q)
      ST_IDLE:    cmd_err_d = rx_vld && !is_cmd(rx_dat[7:0]);
      ST_WR_ADDR: if (rx_vld) rf_addr_d = rx_dat[ADDR_W-1:0];
      ST_WR_DATA: if (rx_vld) begin
        rf_wr_data_d = rx_dat;
        rf_wr_en_d   = 1'b1;
      end
      ST_RD_ADDR: if (rx_vld) begin
        rf_addr_d  = rx_dat[ADDR_W-1:0];
        rf_rd_en_d = 1'b1;
      end
      ST_RD_WAIT: begin
        cmd_err_d = rx_vld;
        resp_load = bus.rf_rd_vld;
        resp_dat  = ALU_W'(bus.rf_rd_data);
      end
      ST_OP_A, ST_OP_B: if (rx_vld) begin
        rf_addr_d    = (state_q == ST_OP_A) ? ADDR_W'(REG_A) : ADDR_W'(REG_B);
        rf_wr_data_d = rx_dat;
        rf_wr_en_d   = 1'b1;
      end
      ST_ALU_FUN: if (rx_vld) begin
        alu_fun_d    = rx_dat[FUN_W-1:0];
        alu_en_d     = 1'b1;
        alu_clk_en_d = 1'b1;
      end
      // Clock gate stays open through the cycle that delivers the result
      ST_ALU_WAIT: begin
        cmd_err_d    = rx_vld;
        alu_clk_en_d = ~bus.alu_out_vld;
        resp_load    = bus.alu_out_vld;
      end
      default:    cmd_err_d = rx_vld;
    endcase
  end

  sys_ctrl_resp_push #(
    .DATA_W (DATA_W),
    .BUF_W  (ALU_W)
  ) u_resp_push (
    .clk          (clk),
    .rst          (rst),
    .load         (resp_load),
    .load_dat     (resp_dat),
    .push_req     (push_req),
    .push_hi      (push_hi),
    .fifo_full    (bus.fifo_full),
    .push_ack     (push_ack),
    .fifo_wr_en   (fifo_wr_en_w),
    .fifo_wr_data (fifo_wr_data_w)
  );

  assign bus.rf_addr      = rf_addr_q;
  assign bus.rf_wr_data   = rf_wr_data_q;
  assign bus.rf_wr_en     = rf_wr_en_q;
  assign bus.rf_rd_en     = rf_rd_en_q;
  assign bus.alu_fun      = alu_fun_q;
  assign bus.alu_en       = alu_en_q;
  assign bus.alu_clk_en   = alu_clk_en_q;
  assign bus.cmd_err      = cmd_err_q;
  assign bus.fifo_wr_en   = fifo_wr_en_w;
  assign bus.fifo_wr_data = fifo_wr_data_w;

endmodule

// File: tb/tb_sys_ctrl_rx_cmd.sv
// Directed-vector bench for sys_ctrl_rx_cmd with hand-computed expectations.
module tb_sys_ctrl_rx_cmd;
  import sys_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sys_ctrl_rx_cmd_if bus ();

  sys_ctrl_rx_cmd dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  logic [11:0] wr_q[$];
  logic [7:0]  push_q[$];
  int          rd_cnt, err_cnt, alu_cnt;
  logic [3:0]  rd_addr_seen, alu_fun_seen;
  logic        both_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rf_wr_en) wr_q.push_back({bus.rf_addr, bus.rf_wr_data});
    if (bus.rf_rd_en) begin rd_cnt++; rd_addr_seen = bus.rf_addr; end
    if (bus.fifo_wr_en) push_q.push_back(bus.fifo_wr_data);
    if (bus.cmd_err) err_cnt++;
    if (bus.alu_en) begin alu_cnt++; alu_fun_seen = bus.alu_fun; end
    if (bus.rf_wr_en && bus.rf_rd_en) both_seen = 1'b1;
  end

  task automatic clr();
    wr_q.delete(); push_q.delete();
    rd_cnt = 0; err_cnt = 0; alu_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_p_data = b;
    bus.rx_d_vld  = 1'b1;
    @(negedge clk);
    bus.rx_d_vld  = 1'b0;
  endtask

  function automatic logic [31:0] out_vec();
    return {2'b0, bus.rf_addr, bus.rf_wr_data, bus.rf_wr_en, bus.rf_rd_en, bus.alu_fun,
            bus.alu_en, bus.alu_clk_en, bus.fifo_wr_data, bus.fifo_wr_en, bus.cmd_err};
  endfunction

  task automatic wait_alu(input string tag);
    for (int i = 0; i < 20 && alu_cnt == 0; i++) @(negedge clk);
    chk(tag, alu_cnt, 1);
  endtask

  task automatic alu_return(input logic [15:0] r);
    bus.alu_out     = r;
    bus.alu_out_vld = 1'b1;
    @(negedge clk);
    bus.alu_out_vld = 1'b0;
  endtask

  initial begin
    bus.rx_p_data = '0; bus.rx_d_vld = 1'b0;
    bus.rf_rd_data = '0; bus.rf_rd_vld = 1'b0;
    bus.alu_out = '0; bus.alu_out_vld = 1'b0;
    bus.fifo_full = 1'b0;
    clr();

    // Reset state
    idle(2);
    chk("rst_outputs", out_vec(), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b1;
    idle(2);

    // Write frame
    clr();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    idle(3);
    chk("wr_count", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("wr_addr_data", 32'(wr_q[0]), 32'h53C);
    chk("wr_no_push", push_q.size(), 0);
    chk("wr_no_err", err_cnt, 0);
    chk("wr_addr_hold", 32'(bus.rf_addr), 32'h5);

    // Read frame, data returned two cycles after rf_rd_en
    clr();
    send_byte(8'hBB); send_byte(8'h07);
    for (int i = 0; i < 20 && rd_cnt == 0; i++) @(negedge clk);
    chk("rd_count", rd_cnt, 1);
    chk("rd_addr", 32'(rd_addr_seen), 32'h7);
    idle(1);
    bus.rf_rd_data = 8'h5A; bus.rf_rd_vld = 1'b1;
    @(negedge clk);
    bus.rf_rd_vld = 1'b0;
    idle(4);
    chk("rd_push_count", push_q.size(), 1);
    if (push_q.size() > 0) chk("rd_push_data", 32'(push_q[0]), 32'h5A);
    chk("rd_no_wr", wr_q.size(), 0);
    chk("rd_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // ALU with operands
    clr();
    send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    wait_alu("op_alu_en");
    chk("op_wr_count", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      chk("op_wr_a", 32'(wr_q[0]), 32'h012);
      chk("op_wr_b", 32'(wr_q[1]), 32'h134);
    end
    chk("op_alu_fun", 32'(alu_fun_seen), 32'h0);
    idle(1);
    chk("op_clk_en_on", 32'(bus.alu_clk_en), 32'h1);
    alu_return(16'h0046);
    idle(4);
    chk("op_clk_en_off", 32'(bus.alu_clk_en), 32'h0);
    chk("op_push_count", push_q.size(), 2);
    if (push_q.size() == 2) begin
      chk("op_push_lo", 32'(push_q[0]), 32'h46);
      chk("op_push_hi", 32'(push_q[1]), 32'h00);
    end

    // ALU without operands, FIFO full; stray byte while waiting
    clr();
    bus.fifo_full = 1'b1;
    send_byte(8'hDD); send_byte(8'h02);
    wait_alu("nop_alu_en");
    chk("nop_alu_fun", 32'(alu_fun_seen), 32'h2);
    send_byte(8'h11);
    idle(2);
    chk("nop_stray_err", err_cnt, 1);
    chk("nop_stray_state", 32'(dut.state_q), 32'(ST_ALU_WAIT));
    alu_return(16'hBEEF);
    idle(5);
    chk("nop_no_push_full", push_q.size(), 0);
    chk("nop_hold_state", 32'(dut.state_q), 32'(ST_PUSH_LO));
    bus.fifo_full = 1'b0;
    idle(4);
    chk("nop_push_count", push_q.size(), 2);
    if (push_q.size() == 2) begin
      chk("nop_push_lo", 32'(push_q[0]), 32'hEF);
      chk("nop_push_hi", 32'(push_q[1]), 32'hBE);
    end

    // Bad opcode then a normal write
    clr();
    send_byte(8'h77);
    idle(2);
    chk("bad_op_err", err_cnt, 1);
    chk("bad_op_no_wr", wr_q.size(), 0);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h99);
    idle(3);
    chk("after_bad_wr_count", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("after_bad_wr", 32'(wr_q[0]), 32'h199);

    // Reset mid-frame
    clr();
    send_byte(8'hAA); send_byte(8'h03);
    rst = 1'b0;
    idle(2);
    chk("midrst_outputs", out_vec(), 32'h0);
    chk("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b1;
    idle(1);
    clr();
    send_byte(8'h3C);
    idle(3);
    chk("midrst_no_wr", wr_q.size(), 0);
    chk("midrst_err", err_cnt, 1);

    chk("wr_rd_exclusive", 32'(both_seen), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
